// File: rtl/flag_pkg.sv
// Shared constants, state encoding and the per-byte decode transform for the flag receive path.
// Combinational helpers only; no latency and no flow control live here.
package flag_pkg;

  localparam int          FLAG_BYTES_DEFAULT = 24;
  localparam logic [63:0] FLAG_PREFIX        = "shc2024{";
  localparam logic [7:0]  FLAG_SUFFIX        = "}";

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Inverse of the encoder transform enc = (plain ^ key) + idx, all mod 256.
  function automatic logic [7:0] decode_byte(input logic [7:0] enc_byte,
                                             input logic [7:0] key,
                                             input logic [7:0] idx);
    return (enc_byte - idx) ^ key;
  endfunction

endpackage

// File: rtl/flag_byte_decode.sv
// Single-byte inverse of the encoder transform: plain = (in_byte - idx) ^ key.
// Purely combinational, zero latency; no handshake.
module flag_byte_decode
  import flag_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic [7:0] key,
  input  logic [7:0] idx,
  output logic [7:0] plain
);

  assign plain = decode_byte(in_byte, key, idx);

endmodule

// File: rtl/flag_decoder.sv
// Decodes the encoded byte stream and reassembles a FLAG_BYTES-byte flag; flag_valid rises on the final accept edge.
// Backpressure: in_ready drops while a completed frame waits in DONE for flag_ack; in_valid low simply stalls.
// Optional FLAG_FORMAT_CHECK_EN adds format_ok (prefix "shc2024{" and suffix "}" check on completion).
module flag_decoder
  import flag_pkg::*;
#(
  parameter int FLAG_BYTES = FLAG_BYTES_DEFAULT,
  parameter int CNT_W      = $clog2(FLAG_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              key,
  input  logic [7:0]              in_byte,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FLAG_BYTES*8-1:0] flag_out,
  output logic                    flag_valid,
  input  logic                    flag_ack,
  output logic                    busy,
`ifdef FLAG_FORMAT_CHECK_EN
  output logic                    format_ok,
`endif
  output logic [CNT_W-1:0]        byte_idx
);

  localparam int               W        = FLAG_BYTES * 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FLAG_BYTES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx_nxt;
  logic [7:0]       idx8;
  logic [7:0]       plain;
  logic             accept;
  logic             complete;

  // Only the lower W-8 bits are ever kept: the top byte of the assembled
  // value is produced on the completing beat and goes straight to flag_out.
  logic [W-9:0]     shift_q;
  logic [W-1:0]     shift_nxt;

  assign idx8      = 8'(byte_idx);
  assign accept    = in_valid && in_ready;
  assign shift_nxt = {shift_q, plain};

  flag_byte_decode u_byte_decode (
    .in_byte (in_byte),
    .key     (key),
    .idx     (idx8),
    .plain   (plain)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = byte_idx;
    in_ready   = 1'b0;
    busy       = 1'b0;
    flag_valid = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_nxt   = CNT_W'(1);
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (byte_idx == LAST_IDX) begin
            complete  = 1'b1;
            idx_nxt   = '0;
            state_nxt = DONE;
          end else begin
            idx_nxt = byte_idx + CNT_W'(1);
          end
        end
      end
      DONE: begin
        flag_valid = 1'b1;
        if (flag_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      shift_q  <= '0;
      flag_out <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
      if (accept)   shift_q  <= shift_nxt[W-9:0];
      if (complete) flag_out <= shift_nxt;
    end
  end

`ifdef FLAG_FORMAT_CHECK_EN
  logic fmt_match;

  assign fmt_match = (shift_nxt[W-1 -: 64] == FLAG_PREFIX) &&
                     (shift_nxt[7:0] == FLAG_SUFFIX);

  always_ff @(posedge clk) begin
    if (reset)         format_ok <= 1'b0;
    else if (complete) format_ok <= fmt_match;
  end
`endif

endmodule

// File: tb/tb_flag_decoder.sv
// Directed bench for flag_decoder: encodes known flags, scoreboards expected frames, checks handshake corners.
module tb_flag_decoder;

  localparam int FB = 24;
  localparam int W  = FB * 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   key;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] flag_out;
  logic         flag_valid;
  logic         flag_ack;
  logic         busy;
  logic [4:0]   byte_idx;
`ifdef FLAG_FORMAT_CHECK_EN
  logic         format_ok;
`endif

  logic [7:0]   d_in, d_key, d_idx, d_plain;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] frame_a, frame_b, exp_f;

  always #5 clk = ~clk;

  flag_decoder #(.FLAG_BYTES(FB)) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flag_out   (flag_out),
    .flag_valid (flag_valid),
    .flag_ack   (flag_ack),
    .busy       (busy),
`ifdef FLAG_FORMAT_CHECK_EN
    .format_ok  (format_ok),
`endif
    .byte_idx   (byte_idx)
  );

  flag_byte_decode u_dec (
    .in_byte (d_in),
    .key     (d_key),
    .idx     (d_idx),
    .plain   (d_plain)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] k, input logic [7:0] idx);
    return (p ^ k) + idx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives bytes [from,to) of frame f back-to-back; key for beat i is kb + i*ks.
  task automatic send_bytes(input logic [W-1:0] f, input logic [7:0] kb, input logic [7:0] ks,
                            input int from, input int to);
    for (int i = from; i < to; i++) begin
      key      = kb + 8'(i) * ks;
      in_byte  = enc(f[W-1-8*i -: 8], key, 8'(i));
      in_valid = 1'b1;
      if (i == FB - 1) exp_q.push_back(f);
      step();
      in_valid = 1'b0;
      chk($sformatf("byte_idx_after_%0d", i), W'(byte_idx), W'((i + 1) % FB));
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (flag_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, W'(flag_valid), W'(1));
    chk({tag, "_sb_nonempty"}, W'(exp_q.size() > 0), W'(1));
    if (exp_q.size() > 0) begin
      exp_f = exp_q.pop_front();
      chk({tag, "_data"}, flag_out, exp_f);
    end
  endtask

  task automatic ack_frame(input string tag);
    flag_ack = 1'b1;
    step();
    flag_ack = 1'b0;
    chk({tag, "_valid_after_ack"}, W'(flag_valid), W'(0));
    chk({tag, "_ready_after_ack"}, W'(in_ready), W'(1));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    flag_ack = 1'b0;
    key      = 8'h00;
    in_byte  = 8'h00;
    frame_a  = "shc2024{this_is_wrooong}";
    frame_b  = "shc2024{this_is_wrooongx";

    // Standalone byte transform, including the mod-256 subtraction wrap.
    d_in = 8'h29; d_key = 8'h5A; d_idx = 8'h00; #1;
    chk("dec_s", W'(d_plain), W'(8'h73));
    d_in = 8'h33; d_key = 8'h5A; d_idx = 8'h01; #1;
    chk("dec_h", W'(d_plain), W'(8'h68));
    d_in = 8'h00; d_key = 8'hFF; d_idx = 8'h01; #1;
    chk("dec_wrap", W'(d_plain), W'(8'h00));

    repeat (2) step();
    chk("rst_idx", W'(byte_idx), W'(0));
    chk("rst_valid", W'(flag_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_ready", W'(in_ready), W'(1));
    chk("rst_flag", flag_out, W'(0));
`ifdef FLAG_FORMAT_CHECK_EN
    chk("rst_fmt", W'(format_ok), W'(0));
`endif
    reset = 1'b0;
    step();

    // Frame A with a 5-cycle stall once ten bytes are in.
    send_bytes(frame_a, 8'h5A, 8'h00, 0, 1);
    chk("beat0_busy", W'(busy), W'(1));
    send_bytes(frame_a, 8'h5A, 8'h00, 1, 10);
    for (int s = 0; s < 5; s++) begin
      in_byte = 8'($urandom);
      key     = 8'($urandom);
      step();
      chk("stall_idx", W'(byte_idx), W'(10));
      chk("stall_valid", W'(flag_valid), W'(0));
      chk("stall_busy", W'(busy), W'(1));
    end
    send_bytes(frame_a, 8'h5A, 8'h00, 10, FB);
    wait_frame("frame_a");
    chk("done_busy", W'(busy), W'(0));
    chk("done_ready", W'(in_ready), W'(0));
`ifdef FLAG_FORMAT_CHECK_EN
    chk("frame_a_fmt", W'(format_ok), W'(1));
`endif

    // Hold in DONE with traffic offered; nothing may be taken.
    in_valid = 1'b1;
    key      = 8'h5A;
    in_byte  = 8'h29;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("hold_ready", W'(in_ready), W'(0));
      chk("hold_valid", W'(flag_valid), W'(1));
      chk("hold_flag", flag_out, frame_a);
      chk("hold_idx", W'(byte_idx), W'(0));
    end
    flag_ack = 1'b1;
    step();
    flag_ack = 1'b0;
    in_valid = 1'b0;
    chk("ack_valid", W'(flag_valid), W'(0));
    chk("ack_idx_not_taken", W'(byte_idx), W'(0));
    chk("ack_busy", W'(busy), W'(0));
    chk("ack_ready", W'(in_ready), W'(1));
    chk("ack_flag_retained", flag_out, frame_a);

    // Frame B: bad suffix.
    send_bytes(frame_b, 8'h5A, 8'h00, 0, FB);
    wait_frame("frame_b");
    chk("frame_b_low", W'(flag_out[7:0]), W'(8'h78));
`ifdef FLAG_FORMAT_CHECK_EN
    chk("frame_b_fmt", W'(format_ok), W'(0));
`endif
    ack_frame("frame_b");

    // Abort a frame at index 12 with ack held high (must be ignored), then reset.
    flag_ack = 1'b1;
    send_bytes(frame_a, 8'hC3, 8'h11, 0, 12);
    flag_ack = 1'b0;
    reset    = 1'b1;
    step();
    chk("mid_rst_idx", W'(byte_idx), W'(0));
    chk("mid_rst_valid", W'(flag_valid), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_ready", W'(in_ready), W'(1));
    chk("mid_rst_flag", flag_out, W'(0));
    reset = 1'b0;

    // Fresh frame with a key that changes every beat.
    send_bytes(frame_a, 8'hC3, 8'h11, 0, FB);
    wait_frame("frame_c");
`ifdef FLAG_FORMAT_CHECK_EN
    chk("frame_c_fmt", W'(format_ok), W'(1));
`endif
    ack_frame("frame_c");
    chk("sb_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
